// File: rtl/mor1kx_branch_pkg.sv
// Shared types and constants for the branch resolve unit and its in-flight queue.
// Optional statistics counters are enabled with the MOR1KX_BRANCH_STATS_EN macro (see top).
package mor1kx_branch_pkg;

  localparam int BRU_ADDR_WIDTH = 32;

  // A not-taken branch resumes after its delay slot.
  localparam logic [BRU_ADDR_WIDTH-1:0] DELAY_SLOT_OFFSET = BRU_ADDR_WIDTH'(8);

  typedef struct packed {
    logic [BRU_ADDR_WIDTH-1:0] pc;
    logic [BRU_ADDR_WIDTH-1:0] target;
    logic                      bf;
    logic                      predicted_flag;
  } entry_t;

  typedef struct packed {
    logic [BRU_ADDR_WIDTH-1:0] pc;
    logic                      taken;
    logic                      mispredict;
  } update_t;

  function automatic logic branch_taken(input logic bf, input logic flag);
    return bf ? flag : ~flag;
  endfunction

endpackage

// File: rtl/mor1kx_branch_inflight_fifo.sv
// Generic in-order FIFO with synchronous clear; a push at full is accepted
// when a pop happens in the same cycle.
module mor1kx_branch_inflight_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             doPush, doPop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rdPtr_q];

  always_comb begin
    doPush  = push_i & (~full_o | pop_i) & ~clr_i;
    doPop   = pop_i & ~empty_o & ~clr_i;
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (clr_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + AW'(1);
      if (doPop)  rdPtr_d = rdPtr_q + AW'(1);
      count_d = count_q + CW'(doPush) - CW'(doPop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; it is only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/mor1kx_branch_resolve_unit.sv
// Resolves predicted conditional branches in order, producing mispredict redirects
// and predictor training updates. Define MOR1KX_BRANCH_STATS_EN for stat counters.
module mor1kx_branch_resolve_unit
  import mor1kx_branch_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = BRU_ADDR_WIDTH,
  parameter int INFLIGHT_DEPTH       = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            push_valid_i,
  output logic                            push_ready_o,
  input  logic                            push_bf_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] push_pc_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] push_target_i,
  input  logic                            push_predicted_flag_i,
  input  logic                            resolve_valid_i,
  output logic                            resolve_ready_o,
  input  logic                            flag_i,
  input  logic                            pipeline_flush_i,
  output logic                            mispredict_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_o,
  output logic                            update_valid_o,
  input  logic                            update_ready_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] update_pc_o,
  output logic                            update_taken_o,
  output logic                            update_mispredict_o,
  output logic                            resolve_err_o,
  output logic [31:0]                     stat_branches_o,
  output logic [31:0]                     stat_mispredicts_o
);

  localparam int CW = $clog2(INFLIGHT_DEPTH) + 1;

  logic                            rstMeta_q, rstSync_q;
  entry_t                          pushEntry, headEntry;
  logic                            fifoFull, fifoEmpty, fifoClr;
  logic [CW-1:0]                   fifoCount;
  logic                            popAccept, pushAccept, popMispredict;
  logic                            resolvedTaken, resolveMismatch;
  logic                            mispredict_q, mispredict_d;
  logic [OPTION_OPERAND_WIDTH-1:0] redirectPc_q, redirectPc_d;
  logic                            updateValid_q, updateValid_d;
  update_t                         update_q, update_d;
  logic                            resolveErr_q, resolveErr_d;

  // Reset asserts asynchronously but releases two clock edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstMeta_q <= 1'b0;
      rstSync_q <= 1'b0;
    end else begin
      rstMeta_q <= 1'b1;
      rstSync_q <= rstMeta_q;
    end
  end

  assign pushEntry = '{pc: push_pc_i, target: push_target_i,
                       bf: push_bf_i, predicted_flag: push_predicted_flag_i};

  mor1kx_branch_inflight_fifo #(
    .DEPTH (INFLIGHT_DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rstSync_q),
    .clr_i   (fifoClr),
    .push_i  (pushAccept),
    .pop_i   (popAccept),
    .wdata_i (pushEntry),
    .rdata_o (headEntry),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  assign push_ready_o    = (fifoCount != CW'(INFLIGHT_DEPTH));
  assign resolve_ready_o = ~updateValid_q | update_ready_i;

  always_comb begin
    resolvedTaken   = branch_taken(headEntry.bf, flag_i);
    resolveMismatch = (flag_i != headEntry.predicted_flag);
    popAccept       = resolve_valid_i & resolve_ready_o & ~fifoEmpty & ~pipeline_flush_i;
    popMispredict   = popAccept & resolveMismatch;
    // Anything pushed alongside a mispredict is on the wrong path.
    fifoClr         = pipeline_flush_i | popMispredict;
    pushAccept      = push_valid_i & (~fifoFull | popAccept) & ~fifoClr;

    mispredict_d    = popMispredict;
    redirectPc_d    = redirectPc_q;
    if (popMispredict)
      redirectPc_d = resolvedTaken ? headEntry.target : headEntry.pc + DELAY_SLOT_OFFSET;

    updateValid_d   = updateValid_q;
    update_d        = update_q;
    if (popAccept) begin
      updateValid_d = 1'b1;
      update_d      = '{pc: headEntry.pc, taken: resolvedTaken, mispredict: resolveMismatch};
    end else if (update_ready_i) begin
      updateValid_d = 1'b0;
    end

    resolveErr_d    = resolveErr_q | (resolve_valid_i & fifoEmpty);
  end

  always_ff @(posedge clk or negedge rstSync_q) begin
    if (!rstSync_q) begin
      mispredict_q  <= 1'b0;
      redirectPc_q  <= '0;
      updateValid_q <= 1'b0;
      update_q      <= '0;
      resolveErr_q  <= 1'b0;
    end else begin
      mispredict_q  <= mispredict_d;
      redirectPc_q  <= redirectPc_d;
      updateValid_q <= updateValid_d;
      update_q      <= update_d;
      resolveErr_q  <= resolveErr_d;
    end
  end

  assign mispredict_o        = mispredict_q;
  assign redirect_pc_o       = redirectPc_q;
  assign update_valid_o      = updateValid_q;
  assign update_pc_o         = update_q.pc;
  assign update_taken_o      = update_q.taken;
  assign update_mispredict_o = update_q.mispredict;
  assign resolve_err_o       = resolveErr_q;

`ifdef MOR1KX_BRANCH_STATS_EN
  logic [31:0] statBranches_q, statMispredicts_q;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rstSync_q) begin
    if (!rstSync_q) begin
      statBranches_q    <= '0;
      statMispredicts_q <= '0;
    end else begin
      if (popAccept && statBranches_q != '1)
        statBranches_q <= statBranches_q + 32'd1;
      if (popMispredict && statMispredicts_q != '1)
        statMispredicts_q <= statMispredicts_q + 32'd1;
    end
  end

  assign stat_branches_o    = statBranches_q;
  assign stat_mispredicts_o = statMispredicts_q;
`else
  assign stat_branches_o    = '0;
  assign stat_mispredicts_o = '0;
`endif

endmodule

// File: tb/tb_mor1kx_branch_resolve_unit.sv
// Self-checking bench for mor1kx_branch_resolve_unit: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_mor1kx_branch_resolve_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        push_valid_i, push_bf_i, push_predicted_flag_i;
  logic [31:0] push_pc_i, push_target_i;
  logic        resolve_valid_i, flag_i, pipeline_flush_i, update_ready_i;
  logic        push_ready_o, resolve_ready_o, mispredict_o, update_valid_o;
  logic [31:0] redirect_pc_o, update_pc_o;
  logic        update_taken_o, update_mispredict_o, resolve_err_o;
  logic [31:0] stat_branches_o, stat_mispredicts_o;

  mor1kx_branch_resolve_unit #(
    .OPTION_OPERAND_WIDTH (32),
    .INFLIGHT_DEPTH       (DEPTH)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .push_valid_i          (push_valid_i),
    .push_ready_o          (push_ready_o),
    .push_bf_i             (push_bf_i),
    .push_pc_i             (push_pc_i),
    .push_target_i         (push_target_i),
    .push_predicted_flag_i (push_predicted_flag_i),
    .resolve_valid_i       (resolve_valid_i),
    .resolve_ready_o       (resolve_ready_o),
    .flag_i                (flag_i),
    .pipeline_flush_i      (pipeline_flush_i),
    .mispredict_o          (mispredict_o),
    .redirect_pc_o         (redirect_pc_o),
    .update_valid_o        (update_valid_o),
    .update_ready_i        (update_ready_i),
    .update_pc_o           (update_pc_o),
    .update_taken_o        (update_taken_o),
    .update_mispredict_o   (update_mispredict_o),
    .resolve_err_o         (resolve_err_o),
    .stat_branches_o       (stat_branches_o),
    .stat_mispredicts_o    (stat_mispredicts_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        bf;
    logic        pred;
  } ent_t;

  // Reference model state: in-flight branches in program order plus expected outputs.
  ent_t        mq[$];
  logic        mMis, mUpdValid, mUpdTaken, mUpdMis, mErr;
  logic [31:0] mRedirect, mUpdPc;
  int unsigned mBranches, mMispredicts;

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic checkRegs(input string tag);
    logic [31:0] expBr, expMis;
`ifdef MOR1KX_BRANCH_STATS_EN
    expBr  = mBranches;
    expMis = mMispredicts;
`else
    expBr  = 32'd0;
    expMis = 32'd0;
`endif
    checkOutput({tag, ".mispredict"}, {31'd0, mispredict_o}, {31'd0, mMis});
    checkOutput({tag, ".redirect"}, redirect_pc_o, mRedirect);
    checkOutput({tag, ".updValid"}, {31'd0, update_valid_o}, {31'd0, mUpdValid});
    checkOutput({tag, ".updPc"}, update_pc_o, mUpdPc);
    checkOutput({tag, ".updTaken"}, {31'd0, update_taken_o}, {31'd0, mUpdTaken});
    checkOutput({tag, ".updMis"}, {31'd0, update_mispredict_o}, {31'd0, mUpdMis});
    checkOutput({tag, ".err"}, {31'd0, resolve_err_o}, {31'd0, mErr});
    checkOutput({tag, ".statBr"}, stat_branches_o, expBr);
    checkOutput({tag, ".statMis"}, stat_mispredicts_o, expMis);
  endtask

  // Drives one cycle of inputs, predicts the outcome from the model, and checks it.
  task automatic applyStimulus(input string tag,
                               input logic pushV, input logic bf, input logic [31:0] pc,
                               input logic [31:0] tgt, input logic pred,
                               input logic resV, input logic flag,
                               input logic flush, input logic updR);
    bit   pop, mis, push, taken, wasEmpty;
    ent_t head, ne;
    push_valid_i          = pushV;
    push_bf_i             = bf;
    push_pc_i             = pc;
    push_target_i         = tgt;
    push_predicted_flag_i = pred;
    resolve_valid_i       = resV;
    flag_i                = flag;
    pipeline_flush_i      = flush;
    update_ready_i        = updR;
    #1;
    checkOutput({tag, ".pushReady"}, {31'd0, push_ready_o}, {31'd0, (mq.size() < DEPTH)});
    checkOutput({tag, ".resReady"}, {31'd0, resolve_ready_o}, {31'd0, (!mUpdValid || updR)});

    wasEmpty = (mq.size() == 0);
    pop      = resV && (!mUpdValid || updR) && !wasEmpty && !flush;
    mis      = 1'b0;
    if (pop) begin
      head  = mq[0];
      taken = head.bf ? flag : !flag;
      mis   = (flag != head.pred);
    end
    push = pushV && (mq.size() < DEPTH || pop) && !flush && !mis;

    if (flush || mis) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        ne = '{pc: pc, tgt: tgt, bf: bf, pred: pred};
        mq.push_back(ne);
      end
    end

    mMis = mis;
    if (mis) mRedirect = taken ? head.tgt : head.pc + 32'd8;
    if (pop) begin
      mUpdValid = 1'b1;
      mUpdPc    = head.pc;
      mUpdTaken = taken;
      mUpdMis   = mis;
      mBranches++;
      if (mis) mMispredicts++;
    end else if (updR) begin
      mUpdValid = 1'b0;
    end
    if (resV && wasEmpty) mErr = 1'b1;

    @(posedge clk);
    #1;
    checkRegs(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    push_valid_i = 0; push_bf_i = 0; push_pc_i = 0; push_target_i = 0;
    push_predicted_flag_i = 0; resolve_valid_i = 0; flag_i = 0;
    pipeline_flush_i = 0; update_ready_i = 1;
    mMis = 0; mUpdValid = 0; mUpdTaken = 0; mUpdMis = 0; mErr = 0;
    mRedirect = 0; mUpdPc = 0; mBranches = 0; mMispredicts = 0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.pushReady", {31'd0, push_ready_o}, 32'd1);
    checkOutput("reset.resReady", {31'd0, resolve_ready_o}, 32'd1);
    checkRegs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkRegs("postReset");

    $display("[TB] correct prediction, l.bf");
    applyStimulus("t1push", 1, 1, 32'h100, 32'h200, 1, 0, 0, 0, 1);
    applyStimulus("t1res", 0, 0, 0, 0, 0, 1, 1, 0, 1);
    checkOutput("t1.updValid", {31'd0, update_valid_o}, 32'd1);
    checkOutput("t1.taken", {31'd0, update_taken_o}, 32'd1);
    checkOutput("t1.mispredict", {31'd0, mispredict_o}, 32'd0);

    $display("[TB] mispredicted l.bnf");
    applyStimulus("t2push", 1, 0, 32'h300, 32'h400, 1, 0, 0, 0, 1);
    applyStimulus("t2res", 0, 0, 0, 0, 0, 1, 0, 0, 1);
    checkOutput("t2.mispredict", {31'd0, mispredict_o}, 32'd1);
    checkOutput("t2.redirect", redirect_pc_o, 32'h400);
    checkOutput("t2.updMis", {31'd0, update_mispredict_o}, 32'd1);
    idle("t2idle");
    checkOutput("t2.pulse", {31'd0, mispredict_o}, 32'd0);

    $display("[TB] fill queue, push and pop at full");
    for (int i = 1; i <= 4; i++)
      applyStimulus("t3fill", 1, 1, 32'(i * 16), 32'h1000, 1, 0, 0, 0, 1);
    checkOutput("t3.full", {31'd0, push_ready_o}, 32'd0);
    applyStimulus("t3both", 1, 1, 32'h50, 32'h1000, 1, 1, 1, 0, 1);
    checkOutput("t3.bothPc", update_pc_o, 32'h10);
    checkOutput("t3.stillFull", {31'd0, push_ready_o}, 32'd0);
    for (int i = 2; i <= 5; i++) begin
      applyStimulus("t3drain", 0, 0, 0, 0, 0, 1, 1, 0, 1);
      checkOutput("t3.order", update_pc_o, 32'(i * 16));
    end

    $display("[TB] mispredict clears queue and drops concurrent push");
    for (int i = 6; i <= 8; i++)
      applyStimulus("t4fill", 1, 1, 32'(i * 16), 32'h2000, 1, 0, 0, 0, 1);
    applyStimulus("t4mis", 1, 1, 32'h90, 32'h2000, 1, 1, 0, 0, 1);
    checkOutput("t4.redirect", redirect_pc_o, 32'h68);
    applyStimulus("t4empty", 0, 0, 0, 0, 0, 1, 1, 0, 1);
    checkOutput("t4.noUpdate", {31'd0, update_valid_o}, 32'd0);
    checkOutput("t4.err", {31'd0, resolve_err_o}, 32'd1);
    idle("t4idle");
    checkOutput("t4.errSticky", {31'd0, resolve_err_o}, 32'd1);

    $display("[TB] update backpressure");
    applyStimulus("t5pushA", 1, 1, 32'hA0, 32'h3000, 1, 0, 0, 0, 0);
    applyStimulus("t5pushB", 1, 1, 32'hB0, 32'h3000, 1, 0, 0, 0, 0);
    applyStimulus("t5resA", 0, 0, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus("t5hold", 0, 0, 0, 0, 0, 1, 1, 0, 0);
    checkOutput("t5.resReady", {31'd0, resolve_ready_o}, 32'd0);
    checkOutput("t5.holdPc", update_pc_o, 32'hA0);
    applyStimulus("t5resB", 0, 0, 0, 0, 0, 1, 1, 0, 1);
    checkOutput("t5.pcB", update_pc_o, 32'hB0);
    idle("t5idle");

    $display("[TB] pipeline flush");
    applyStimulus("t6pushC", 1, 1, 32'hC0, 32'h4000, 1, 0, 0, 0, 1);
    applyStimulus("t6pushD", 1, 1, 32'hD0, 32'h4000, 1, 0, 0, 0, 1);
    applyStimulus("t6flush", 1, 1, 32'hE0, 32'h4000, 1, 1, 0, 1, 1);
    checkOutput("t6.noMis", {31'd0, mispredict_o}, 32'd0);
    checkOutput("t6.noUpd", {31'd0, update_valid_o}, 32'd0);
    applyStimulus("t6after", 0, 0, 0, 0, 0, 1, 1, 0, 1);
    checkOutput("t6.empty", {31'd0, update_valid_o}, 32'd0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      applyStimulus("rand",
                    ($urandom_range(0, 99) < 60), 1'($urandom), {$urandom, 2'b00},
                    {$urandom, 2'b00}, 1'($urandom),
                    ($urandom_range(0, 99) < 50), 1'($urandom),
                    ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 75));
    end
    idle("final");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation timeout");
  end

endmodule
